rf_writeback: RTL and testbench

- Write-side master for the 32x32 register file. It owns the single write port (we/rd/wd).
- Merges results from two producers:
  - port A: single-cycle ALU path, normally has priority.
  - port B: long-latency load/mul path, buffered in a FIFO.
- Issues at most one register write per cycle and drops writes to x0.
- Exposes two hazard-lookup ports so issue logic can stall on registers with pending writes.

---
 rtl/wb_pkg.sv | 16 +
 rtl/rf_writeback_if.sv | 40 ++++
 rtl/wb_fifo.sv | 67 ++++++
 rtl/rf_writeback.sv | 120 ++++++++++++
 tb/tb_rf_writeback.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_pkg
// Brief  : Shared widths and the write-back request record.
// Rev    : 1.0  initial release
// ============================================================================
package wb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage
`default_nettype wire

// File: rtl/rf_writeback_if.sv
`default_nettype none
// ============================================================================
// Module : rf_writeback_if
// Brief  : Producer handshakes, register-file write port and hazard lookups.
// Rev    : 1.0  initial release
// ============================================================================
interface rf_writeback_if #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic            a_valid;
  logic            a_ready;
  logic [4:0]      a_rd;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [4:0]      b_rd;
  logic [XLEN-1:0] b_data;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic [4:0]      chk_rs1;
  logic [4:0]      chk_rs2;
  logic            chk_busy1;
  logic            chk_busy2;
  logic [CW-1:0]   fifo_count;

  modport master (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, chk_rs1, chk_rs2,
    output a_ready, b_ready, rf_we, rf_rd, rf_wd, chk_busy1, chk_busy2, fifo_count
  );

  modport slave (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data, chk_rs1, chk_rs2,
    input  a_ready, b_ready, rf_we, rf_rd, rf_wd, chk_busy1, chk_busy2, fifo_count
  );
endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module : wb_fifo
// Brief  : Synchronous FIFO of write-back requests with per-entry rd exposure.
// Rev    : 1.0  initial release
// ============================================================================
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  wb_req_t                             push_req,
  input  logic                                pop,
  output wb_req_t                             head,
  output logic [$clog2(DEPTH+1)-1:0]          count,
  output logic                                full,
  output logic                                empty,
  output logic [DEPTH-1:0]                    ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_rd
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);
  localparam logic [CW-1:0] c_cnt_one = CW'(1);
  localparam logic [CW-1:0] c_cnt_max = CW'(DEPTH);

  wb_req_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_req;
        r_wr_ptr        <= r_wr_ptr + c_ptr_one;
      end
      if (pop) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({push, pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == c_cnt_max);
  assign empty = (r_count == '0);

  // An entry is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [AW-1:0] w_off;
    assign w_off        = AW'(i) - r_rd_ptr;
    assign ent_valid[i] = ({1'b0, w_off} < r_count);
    assign ent_rd[i]    = r_mem[i].rd;
  end
endmodule
`default_nettype wire

// File: rtl/rf_writeback.sv
`default_nettype none
// ============================================================================
// Module : rf_writeback
// Brief  : Single write-port arbiter merging ALU (A) and buffered long-latency (B) results.
// Rev    : 1.0  initial release
// ============================================================================
module rf_writeback
  import wb_pkg::*;
#(
  parameter int XLEN       = wb_pkg::XLEN,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          reset,
  rf_writeback_if.master bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [SW-1:0]         c_starve_max = SW'(STARVE_MAX);
  localparam logic [SW-1:0]         c_starve_one = SW'(1);
  localparam logic [REG_ADDR_W-1:0] c_x0         = '0;

  logic [XLEN-1:0]                       w_a_data;
  logic                                  w_push;
  logic                                  w_pop;
  wb_req_t                               w_push_req;
  wb_req_t                               w_head;
  wb_req_t                               w_sel;
  logic [CW-1:0]                         w_count;
  logic                                  w_full;
  logic                                  w_empty;
  logic [FIFO_DEPTH-1:0]                 w_ent_valid;
  logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] w_ent_rd;
  logic [FIFO_DEPTH-1:0]                 w_hit1;
  logic [FIFO_DEPTH-1:0]                 w_hit2;
  logic                                  w_force_b;
  logic                                  w_we;
  logic [SW-1:0]                         w_starve_nxt;

  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_wd;
  logic [SW-1:0]         r_starve;

  assign w_a_data   = bus.a_data;
  assign w_push_req = '{rd: bus.b_rd, data: bus.b_data};
  assign w_push     = bus.b_valid && bus.b_ready && (bus.b_rd != c_x0);

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_req  (w_push_req),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty),
    .ent_valid (w_ent_valid),
    .ent_rd    (w_ent_rd)
  );

  assign w_force_b   = (r_starve == c_starve_max) && !w_empty;
  assign bus.a_ready = reset && !w_force_b;
  assign bus.b_ready = reset && !w_full;

  // Slot priority: starved B, then a real A write, then any queued B.
  always_comb begin
    w_pop        = 1'b0;
    w_we         = 1'b0;
    w_sel        = '0;
    w_starve_nxt = '0;
    if (w_force_b) begin
      w_pop = 1'b1;
      w_we  = 1'b1;
      w_sel = w_head;
    end else if (bus.a_valid && (bus.a_rd != c_x0)) begin
      w_we  = 1'b1;
      w_sel = '{rd: bus.a_rd, data: w_a_data};
      if (!w_empty)
        w_starve_nxt = (r_starve == c_starve_max) ? r_starve : r_starve + c_starve_one;
    end else if (!w_empty) begin
      w_pop = 1'b1;
      w_we  = 1'b1;
      w_sel = w_head;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_we     <= 1'b0;
      r_rd     <= '0;
      r_wd     <= '0;
      r_starve <= '0;
    end else begin
      r_we     <= w_we;
      r_starve <= w_starve_nxt;
      if (w_we) begin
        r_rd <= w_sel.rd;
        r_wd <= w_sel.data;
      end
    end
  end

  assign bus.rf_we      = r_we;
  assign bus.rf_rd      = r_rd;
  assign bus.rf_wd      = r_wd;
  assign bus.fifo_count = w_count;

  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_hit
    assign w_hit1[i] = w_ent_valid[i] && (w_ent_rd[i] == bus.chk_rs1);
    assign w_hit2[i] = w_ent_valid[i] && (w_ent_rd[i] == bus.chk_rs2);
  end

  // The in-flight output register counts as pending until the RF edge lands.
  assign bus.chk_busy1 = (bus.chk_rs1 != c_x0) && ((|w_hit1) || (r_we && (r_rd == bus.chk_rs1)));
  assign bus.chk_busy2 = (bus.chk_rs2 != c_x0) && ((|w_hit2) || (r_we && (r_rd == bus.chk_rs2)));
endmodule
`default_nettype wire

// File: tb/tb_rf_writeback.sv
`default_nettype none
// ============================================================================
// Module : tb_rf_writeback
// Brief  : Directed stimulus with an expected-write scoreboard for rf_writeback.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rf_writeback;
  import wb_pkg::*;

  localparam int FD = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rf_writeback_if #(.XLEN(32), .FIFO_DEPTH(FD)) bus ();

  rf_writeback #(.XLEN(32), .FIFO_DEPTH(FD), .STARVE_MAX(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wb_req_t exp_q[$];
  int      n_vec = 0;
  int      n_err = 0;

  int   exp_cnt [9] = '{0, 1, 2, 3, 4, 3, 4, 4, 4};
  logic exp_ar  [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 0};
  logic exp_br  [9] = '{1, 1, 1, 1, 0, 1, 0, 0, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input int rd, input int data);
    exp_q.push_back('{rd: 5'(rd), data: 32'(data)});
  endtask

  // Monitor: every write the DUT presents must match the scoreboard head.
  always @(negedge clk) begin : mon
    wb_req_t e;
    if (bus.rf_we === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got rd=%0d wd=%0h, expected no write", bus.rf_rd, bus.rf_wd);
      end else begin
        e = exp_q.pop_front();
        if (bus.rf_rd !== e.rd || bus.rf_wd !== e.data) begin
          n_err++;
          $display("FAIL write_order: got rd=%0d wd=%0h, expected rd=%0d wd=%0h",
                   bus.rf_rd, bus.rf_wd, e.rd, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin : stim
    int ai;
    int bi;
    bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
    bus.chk_rs1 = '0;   bus.chk_rs2 = '0;

    // Reset held with producers active
    bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'h1;
    bus.b_valid = 1'b1; bus.b_rd = 5'd5; bus.b_data = 32'h2;
    repeat (3) begin
      tick();
      chk("rst_we", bus.rf_we, 0);
      chk("rst_a_ready", bus.a_ready, 0);
      chk("rst_b_ready", bus.b_ready, 0);
      chk("rst_count", bus.fifo_count, 0);
    end
    chk("rst_rd", bus.rf_rd, 0);
    chk("rst_wd", bus.rf_wd, 0);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    reset = 1'b1;
    tick();

    // A path
    bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'h64;
    expect_wr(3, 'h64);
    #1 chk("a_ready", bus.a_ready, 1);
    tick();
    bus.a_valid = 1'b0;
    chk("a_we_t1", bus.rf_we, 1);
    chk("a_rd_t1", bus.rf_rd, 3);
    chk("a_wd_t1", bus.rf_wd, 'h64);
    tick();
    chk("a_we_t2", bus.rf_we, 0);
    chk("a_rd_hold", bus.rf_rd, 3);

    // B path, empty FIFO
    bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'hDEAD; bus.chk_rs1 = 5'd7;
    expect_wr(7, 'hDEAD);
    #1 chk("b_busy_t0", bus.chk_busy1, 0);
    tick();
    bus.b_valid = 1'b0;
    #1;
    chk("b_busy_t1", bus.chk_busy1, 1);
    chk("b_we_t1", bus.rf_we, 0);
    chk("b_count_t1", bus.fifo_count, 1);
    tick();
    chk("b_busy_t2", bus.chk_busy1, 1);
    chk("b_we_t2", bus.rf_we, 1);
    chk("b_rd_t2", bus.rf_rd, 7);
    chk("b_count_t2", bus.fifo_count, 0);
    tick();
    chk("b_busy_t3", bus.chk_busy1, 0);
    bus.chk_rs1 = '0;

    // Starvation: B rd=9 queued behind a filler A write, then A rd 1..4
    expect_wr(10, 'h10A); expect_wr(1, 'h101); expect_wr(2, 'h102);
    expect_wr(3, 'h103);  expect_wr(9, 'h99);  expect_wr(4, 'h104);
    bus.a_valid = 1'b1; bus.a_rd = 5'd10; bus.a_data = 32'h10A;
    bus.b_valid = 1'b1; bus.b_rd = 5'd9;  bus.b_data = 32'h99;
    bus.chk_rs2 = 5'd9;
    tick();
    bus.b_valid = 1'b0;
    #1 chk("starve_busy2", bus.chk_busy2, 1);
    for (int k = 1; k <= 3; k++) begin
      bus.a_rd = 5'(k); bus.a_data = 32'h100 + 32'(k);
      #1 chk("starve_a_ready", bus.a_ready, 1);
      tick();
    end
    bus.a_rd = 5'd4; bus.a_data = 32'h104;
    #1 chk("starve_forced", bus.a_ready, 0);
    tick();
    chk("starve_b_rd", bus.rf_rd, 9);
    chk("starve_a_ready_back", bus.a_ready, 1);
    tick();
    chk("starve_a4_rd", bus.rf_rd, 4);
    bus.a_valid = 1'b0; bus.chk_rs2 = '0;
    tick();

    // x0 handling
    expect_wr(12, 'h112); expect_wr(6, 'h66);
    bus.a_valid = 1'b1; bus.a_rd = 5'd12; bus.a_data = 32'h112;
    bus.b_valid = 1'b1; bus.b_rd = 5'd6;  bus.b_data = 32'h66;
    tick();
    bus.b_valid = 1'b0; bus.a_rd = 5'd0; bus.a_data = 32'h55;
    #1 chk("x0_a_ready", bus.a_ready, 1);
    tick();
    bus.a_valid = 1'b0;
    chk("x0_pop_rd", bus.rf_rd, 6);
    chk("x0_pop_we", bus.rf_we, 1);
    bus.b_valid = 1'b1; bus.b_rd = 5'd0; bus.b_data = 32'h77;
    #1 chk("x0_b_ready", bus.b_ready, 1);
    tick();
    bus.b_valid = 1'b0;
    chk("x0_b_count", bus.fifo_count, 0);
    tick();
    chk("x0_b_nowrite", bus.rf_we, 0);

    // Full FIFO under A saturation, then reset with entries queued
    for (int i = 0; i < 4; i++) expect_wr(13 + i, 'h200 + i);
    expect_wr(20, 'h300);
    for (int i = 4; i < 7; i++) expect_wr(13 + i, 'h200 + i);
    expect_wr(21, 'h301);
    ai = 0; bi = 0;
    for (int c = 0; c < 9; c++) begin
      bus.a_valid = 1'b1; bus.a_rd = 5'(13 + ai); bus.a_data = 32'h200 + 32'(ai);
      bus.b_valid = (bi < 5); bus.b_rd = 5'(20 + bi); bus.b_data = 32'h300 + 32'(bi);
      #1;
      chk("full_count", bus.fifo_count, exp_cnt[c]);
      chk("full_a_ready", bus.a_ready, exp_ar[c]);
      chk("full_b_ready", bus.b_ready, exp_br[c]);
      tick();
      if (exp_ar[c]) ai++;
      if (exp_br[c] && bi < 5) bi++;
    end
    reset = 1'b0; bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    #1;
    chk("pre_rst_count", bus.fifo_count, 3);
    chk("pre_rst_rd", bus.rf_rd, 21);
    chk("rst_mid_a_ready", bus.a_ready, 0);
    chk("rst_mid_b_ready", bus.b_ready, 0);
    tick();
    chk("rst_mid_we", bus.rf_we, 0);
    chk("rst_mid_count", bus.fifo_count, 0);
    reset = 1'b1;
    tick();
    chk("post_rst_we", bus.rf_we, 0);
    chk("post_rst_count", bus.fifo_count, 0);
    tick();
    chk("post_rst_we2", bus.rf_we, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
